// File: rtl/ppu_vram_arbiter.sv
// Generic FIFO: registered storage, head visible combinationally, occupancy-decoded full flag.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: in_rdy drops when full unless the head is popped in the same cycle.
module ppu_vram_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             in_rdy,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign out_vld = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign pop     = out_vld && out_rdy;
    assign in_rdy  = !full || pop;
    assign push    = in_vld && in_rdy;
    assign out_dat = mem[rd_ptr];

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Pointer and occupancy bookkeeping; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// PPU VRAM arbiter: fixed-priority bg > spr > cpu, nametable mirroring, $2007 read buffer.
// Latency: fetch data one cycle after grant; CPU ack two cycles after cpu_req when memory is idle.
// Backpressure: fetches never stall; CPU requests wait in a 2-deep queue, dropped (sticky ovf) when full.
module ppu_vram_arbiter #(
    parameter bit MIRROR         = 1'b0,
    parameter int CPU_FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rendering,
    input  logic        bg_req,
    input  logic [13:0] bg_addr,
    output logic        bg_gnt,
    output logic        bg_rvalid,
    input  logic        spr_req,
    input  logic [13:0] spr_addr,
    output logic        spr_gnt,
    output logic        spr_rvalid,
    output logic [7:0]  rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_full,
    output logic        cpu_ovf,
    output logic        mem_en,
    output logic        mem_we,
    output logic [13:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);
    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  wdata;
    } cpu_ent_t;

    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_BG,
        OWN_SPR,
        OWN_CPU_RD,
        OWN_CPU_WR
    } owner_t;

    // Fold $3000-$3EFF onto $2000, then collapse the four logical nametables onto two physical ones.
    function automatic logic [13:0] mirror_addr(input logic [13:0] a);
        logic [13:0] f;
        f = a;
        if (a >= 14'h3000 && a < 14'h3F00) begin
            f = {2'b10, a[11:0]};
        end
        if (f[13:12] == 2'b10) begin
            if (MIRROR) begin
                mirror_addr = {3'b100, f[10:0]};
            end else begin
                mirror_addr = {3'b100, f[11], f[9:0]};
            end
        end else begin
            mirror_addr = f;
        end
    endfunction

    cpu_ent_t cpu_in;
    cpu_ent_t head;
    logic     head_vld;
    logic     fifo_in_rdy;
    logic     bg_win;
    logic     spr_win;
    logic     cpu_win;
    logic     rd_done;
    owner_t   owner_q;
    logic     pal_q;
    logic [7:0] rbuf_q;
    logic [7:0] rdata_q;
    logic [7:0] cpu_rdata_q;

    assign cpu_in = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};

    ppu_vram_fifo #(
        .WIDTH ($bits(cpu_ent_t)),
        .DEPTH (CPU_FIFO_DEPTH)
    ) u_cpu_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (cpu_req),
        .in_dat  (cpu_in),
        .in_rdy  (fifo_in_rdy),
        .out_vld (head_vld),
        .out_rdy (cpu_win),
        .out_dat (head),
        .full    (cpu_full)
    );

    // Fetches only compete while rendering; the CPU takes any cycle no fetch is granted.
    assign bg_win  = reset && rendering && bg_req;
    assign spr_win = reset && rendering && spr_req && !bg_req;
    assign cpu_win = reset && head_vld && !(rendering && (bg_req || spr_req));

    assign bg_gnt  = bg_win;
    assign spr_gnt = spr_win;

    // Completion side is decoded from the owner registered at issue; reset discards it.
    assign bg_rvalid  = reset && (owner_q == OWN_BG);
    assign spr_rvalid = reset && (owner_q == OWN_SPR);
    assign rd_done    = reset && (owner_q == OWN_CPU_RD);
    assign cpu_ack    = rd_done || (reset && (owner_q == OWN_CPU_WR));
    assign rdata      = (bg_rvalid || spr_rvalid) ? mem_rdata : rdata_q;
    // Palette reads bypass the buffer; everything else returns the previous read.
    assign cpu_rdata  = rd_done ? (pal_q ? mem_rdata : rbuf_q) : cpu_rdata_q;

    // Drive the VRAM port from whichever requester won this cycle.
    always_comb begin
        mem_en    = bg_win || spr_win || cpu_win;
        mem_we    = cpu_win && head.we;
        mem_addr  = 14'h0;
        mem_wdata = 8'h00;
        if (bg_win) begin
            mem_addr = mirror_addr(bg_addr);
        end else if (spr_win) begin
            mem_addr = mirror_addr(spr_addr);
        end else if (cpu_win) begin
            mem_addr = mirror_addr(head.addr);
        end
        if (mem_we) begin
            mem_wdata = head.wdata;
        end
    end

    // Owner tag, held read data, $2007 read buffer and overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q     <= OWN_NONE;
            pal_q       <= 1'b0;
            rbuf_q      <= 8'h00;
            rdata_q     <= 8'h00;
            cpu_rdata_q <= 8'h00;
            cpu_ovf     <= 1'b0;
        end else begin
            if (bg_rvalid || spr_rvalid) begin
                rdata_q <= mem_rdata;
            end
            if (rd_done) begin
                cpu_rdata_q <= cpu_rdata;
                rbuf_q      <= mem_rdata;
            end
            if (cpu_req && !fifo_in_rdy) begin
                cpu_ovf <= 1'b1;
            end
            if (bg_win) begin
                owner_q <= OWN_BG;
            end else if (spr_win) begin
                owner_q <= OWN_SPR;
            end else if (cpu_win) begin
                owner_q <= head.we ? OWN_CPU_WR : OWN_CPU_RD;
            end else begin
                owner_q <= OWN_NONE;
            end
            if (cpu_win) begin
                pal_q <= (head.addr >= 14'h3F00);
            end
        end
    end
endmodule

// File: doc/ppu_vram_arbiter.md
# ppu_vram_arbiter

Arbiter and sequencer for the single-port PPU VRAM shared by the background fetcher, the sprite fetcher and the CPU PPUDATA ($2007) port. During rendering it gives fetch requesters fixed-priority access to VRAM. CPU accesses are queued in a 2-entry FIFO and issued in free cycles. The block applies nametable mirroring and implements the $2007 buffered-read behaviour. It sits between the PPU fetch engines / CPU register file and the VRAM/CHR memory.

## Interface
- MIRROR, 0, nametable mirroring: 0 = horizontal, 1 = vertical
- CPU_FIFO_DEPTH, 2, CPU request queue depth (fixed 2; other values unsupported)

- clk  in  1  PPU clock; all logic on posedge
- reset  in  1  synchronous, active-low reset
- rendering  in  1  high while fetch windows are active (visible lines and pre-render)
- bg_req  in  1  background fetch request
- bg_addr  in  14  background fetch address
- bg_gnt  out  1  request issued this cycle
- bg_rvalid  out  1  `rdata` holds bg data
- spr_req  in  1  sprite fetch request
- spr_addr  in  14  sprite fetch address
- spr_gnt  out  1  request issued this cycle
- spr_rvalid  out  1  `rdata` holds sprite data
- rdata  out  8  fetch read data; registered copy of `mem_rdata`
- cpu_req  in  1  one-cycle pulse: CPU $2007 access
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  14  LoopyV address at time of access
- cpu_wdata  in  8  write data
- cpu_ack  out  1  one-cycle pulse when a CPU access completes
- cpu_rdata  out  8  $2007 read result; valid with `cpu_ack` on reads, held until the next read completes
- cpu_full  out  1  CPU FIFO holds 2 entries
- cpu_ovf  out  1  sticky: a `cpu_req` was dropped; cleared only by reset
- mem_en  out  1  VRAM access strobe
- mem_we  out  1  VRAM write strobe
- mem_addr  out  14  physical VRAM address, after mirroring
- mem_wdata  out  8  VRAM write data
- mem_rdata  in  8  VRAM read data; valid the cycle after `mem_en` with `mem_we` = 0

## Operation
- Reset values (reset = 0 at posedge):
  - all gnt/rvalid/ack/mem_* outputs are 0
  - `rdata` = 0, `cpu_rdata` = 0
  - read buffer = 0
  - FIFO empty, `cpu_full` = 0, `cpu_ovf` = 0
  - owner tag = NONE
- Arbitration is combinational each cycle, with priority bg > spr > cpu.
  - `bg_req` and `spr_req` are honoured only when `rendering` = 1; otherwise they are ignored (gnt = 0).
  - The CPU FIFO head is issued only in a cycle where no fetch request is granted.
- Grant: `bg_gnt`/`spr_gnt` assert combinationally in the issue cycle. `mem_en` = 1, and `mem_addr` is the mirrored address of the winner.
- Owner tag states: NONE, BG, SPR, CPU_RD, CPU_WR. The tag is registered at issue and decoded one cycle later:
  - BG → `bg_rvalid` = 1 and `rdata` = `mem_rdata`.
  - SPR → `spr_rvalid` = 1 and `rdata` = `mem_rdata`.
  - CPU_RD → read completion (see below).
  - CPU_WR → `cpu_ack` = 1.
- Mirroring, applied to every requester:
  - Addresses 0x3000–0x3EFF are first folded to 0x2000–0x2EFF.
  - Range 0x2000–0x2FFF:
    - MIRROR = 1: physical address = 0x2000 | A[10:0].
    - MIRROR = 0: physical address = 0x2000 | (A[11] << 10) | A[9:0].
  - Addresses below 0x2000 and at or above 0x3F00 pass unchanged.
- CPU FIFO:
  - Each entry holds {we, addr, wdata}.
  - `cpu_req` enqueues when not full. When full, the request is dropped and `cpu_ovf` is set.
  - Enqueue and dequeue in the same cycle are both performed; a full FIFO can accept in a cycle where it issues.
- Buffered read, on CPU_RD completion:
  - Address below 0x3F00: `cpu_rdata` = old read buffer; read buffer ← `mem_rdata`.
  - Address at or above 0x3F00 (palette): `cpu_rdata` = `mem_rdata`; read buffer ← `mem_rdata`.
  - `cpu_ack` = 1.
- CPU write: `mem_we` = 1 and `mem_wdata` = entry data in the issue cycle.
- Changes to `rendering` take effect in the same cycle. An access already in flight (registered tag) completes normally.
- Reset asserted mid-access: the in-flight result is discarded (no rvalid/ack) and the FIFO is flushed.

## Timing
- Fetch latency: issue at cycle N, rvalid and `rdata` at N+1. Back-to-back grants are allowed every cycle.
- CPU latency with memory idle: `cpu_req` at N → enqueue at N, issue at N+1, `cpu_ack` at N+2.
- CPU worst case: waits until the first cycle with no granted fetch. There is no starvation timeout. Software keeps $2007 traffic in vblank, where `rendering` = 0.
- `cpu_full` is registered from FIFO occupancy and is valid the cycle after the change.
- At most one `mem_en` per cycle. Exactly one of bg/spr/cpu may be the owner per cycle.

## Test plan
- Reset, then `rendering` = 0, cpu write 0x2005 ← 0xA5 → `mem_we` with `mem_addr` 0x2005 at N+1; `cpu_ack` at N+2.
- MIRROR = 0: cpu read 0x2C10 twice (`mem_rdata` 0x3C) → first `cpu_rdata` = 0x00 (stale buffer), second = 0x3C; `mem_addr` = 0x2410.
- MIRROR = 1: read 0x3F01 (`mem_rdata` 0x16) → `cpu_rdata` = 0x16 on the first ack; read 0x3810 → `mem_addr` 0x2010.
- `rendering` = 1 with `bg_req` and `spr_req` high continuously, cpu read pending → only `bg_gnt`; cpu issued in the first cycle with `bg_req` = 0 and `spr_req` = 0; `bg_rvalid` one cycle after each grant.
- `rendering` = 1 with `bg_req` held, three `cpu_req` pulses → `cpu_full` = 1 after two, `cpu_ovf` = 1, only two acks once `bg_req` drops.
- Reset pulsed one cycle after a cpu read issues → no `cpu_ack`, FIFO empty, read buffer = 0.
